// File: rtl/calc_pkg.sv
// Shared types and default widths for the calculator command sequencer.
package calc_pkg;

  localparam int unsigned CALC_ADDR_W = 8;
  localparam int unsigned CALC_OPND_W = 8;
  localparam int unsigned CALC_SEL_W  = 4;
  localparam int unsigned CALC_ALU_W  = 16;
  localparam int unsigned CALC_DATA_W = 32;
  localparam int unsigned CALC_KEY_W  = 4;

  localparam logic [CALC_KEY_W-1:0] CALC_KEY_SEQ = 4'b1011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_EXEC,
    ST_WRITE,
    ST_RD_REQ,
    ST_RD_CAP,
    ST_TX
  } state_t;

  typedef struct packed {
    logic                   rw;
    logic [CALC_ADDR_W-1:0] addr;
    logic [CALC_OPND_W-1:0] ina;
    logic [CALC_OPND_W-1:0] inb;
    logic [CALC_SEL_W-1:0]  sel;
  } cmd_t;

  function automatic logic is_busy(input state_t s);
    return s inside {ST_EXEC, ST_WRITE, ST_RD_REQ, ST_RD_CAP, ST_TX};
  endfunction

endpackage

// File: rtl/calc_key_detect.sv
// Serial activation-key detector: LSB-entry shift register, 1-cycle match pulse,
// register cleared on a match so consecutive patterns never overlap.
module calc_key_detect
  import calc_pkg::*;
#(
  parameter int unsigned           KEY_W   = CALC_KEY_W,
  parameter logic [KEY_W-1:0]      KEY_SEQ = CALC_KEY_SEQ
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic key_in,
  output logic match_o
);

  logic [KEY_W-1:0] shift_q;
  logic [KEY_W-1:0] shift_d;
  logic [KEY_W-1:0] shifted;

  always_comb begin
    shifted = {shift_q[KEY_W-2:0], key_in};
    match_o = en && (shifted == KEY_SEQ);
    shift_d = shift_q;
    if (en) begin
      shift_d = match_o ? '0 : shifted;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator command sequencer: key activation, ALU/memory/serializer sequencing.
// Optional one-entry pending-command slot enabled by `define CALC_CMD_QUEUE_EN.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned           ADDR_W  = CALC_ADDR_W,
  parameter int unsigned           OPND_W  = CALC_OPND_W,
  parameter int unsigned           SEL_W   = CALC_SEL_W,
  parameter int unsigned           ALU_W   = CALC_ALU_W,
  parameter int unsigned           DATA_W  = CALC_DATA_W,
  parameter logic [CALC_KEY_W-1:0] KEY_SEQ = CALC_KEY_SEQ
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              InputKey,
  input  logic              ValidCmd,
  input  logic              RW,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [OPND_W-1:0] InA,
  input  logic [OPND_W-1:0] InB,
  input  logic [SEL_W-1:0]  Sel,
  output logic              AluEn,
  output logic [OPND_W-1:0] AluA,
  output logic [OPND_W-1:0] AluB,
  output logic [SEL_W-1:0]  AluSel,
  input  logic [ALU_W-1:0]  AluResult,
  output logic              MemWe,
  output logic              MemRe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWdata,
  input  logic [DATA_W-1:0] MemRdata,
  output logic              SerStart,
  output logic [DATA_W-1:0] SerData,
  input  logic              SerDone,
  output logic              CalcActive,
  output logic              CalcMode,
  output logic              Busy
);

  state_t            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] ser_data_q, ser_data_d;
  logic              busy;
  logic              key_en;
  logic              key_match;
  cmd_t              in_cmd;
  logic              disp_valid;
  cmd_t              disp_cmd;

  assign busy   = is_busy(state_q);
  assign key_en = ~busy;
  assign in_cmd = '{rw: RW, addr: Addr, ina: InA, inb: InB, sel: Sel};

  calc_key_detect #(
    .KEY_W  (CALC_KEY_W),
    .KEY_SEQ(KEY_SEQ)
  ) u_key_detect (
    .clk    (Clk),
    .rst_n  (Reset),
    .en     (key_en),
    .key_in (InputKey),
    .match_o(key_match)
  );

`ifdef CALC_CMD_QUEUE_EN
  logic pend_valid_q, pend_valid_d;
  cmd_t pend_cmd_q, pend_cmd_d;

  // A parked command takes priority over a fresh strobe on return to ACTIVE.
  assign disp_valid = pend_valid_q | ValidCmd;
  assign disp_cmd   = pend_valid_q ? pend_cmd_q : in_cmd;

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_cmd_d   = pend_cmd_q;
    if (busy && ValidCmd && !pend_valid_q) begin
      pend_valid_d = 1'b1;
      pend_cmd_d   = in_cmd;
    end else if (state_q == ST_ACTIVE) begin
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pend_valid_q <= 1'b0;
      pend_cmd_q   <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_cmd_q   <= pend_cmd_d;
    end
  end
`else
  assign disp_valid = ValidCmd;
  assign disp_cmd   = in_cmd;
`endif

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    wdata_d    = wdata_q;
    ser_data_d = ser_data_q;
    case (state_q)
      ST_IDLE: begin
        if (key_match) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (key_match) begin
          state_d = ST_IDLE;
        end else if (disp_valid) begin
          cmd_d   = disp_cmd;
          state_d = disp_cmd.rw ? ST_EXEC : ST_RD_REQ;
        end
      end
      ST_EXEC: begin
        wdata_d = DATA_W'(AluResult);
        state_d = ST_WRITE;
      end
      ST_WRITE:  state_d = ST_ACTIVE;
      ST_RD_REQ: state_d = ST_RD_CAP;
      ST_RD_CAP: begin
        ser_data_d = MemRdata;
        state_d    = ST_TX;
      end
      ST_TX: begin
        if (SerDone) state_d = ST_ACTIVE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      wdata_q    <= '0;
      ser_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      wdata_q    <= wdata_d;
      ser_data_q <= ser_data_d;
    end
  end

  // Read data bypasses the capture register during the start cycle so SerData
  // is already valid alongside SerStart and stays held through TX.
  assign SerData    = (state_q == ST_RD_CAP) ? MemRdata : ser_data_q;
  assign AluEn      = (state_q == ST_EXEC);
  assign AluA       = cmd_q.ina;
  assign AluB       = cmd_q.inb;
  assign AluSel     = cmd_q.sel;
  assign MemWe      = (state_q == ST_WRITE);
  assign MemRe      = (state_q == ST_RD_REQ);
  assign MemAddr    = cmd_q.addr;
  assign MemWdata   = wdata_q;
  assign SerStart   = (state_q == ST_RD_CAP);
  assign CalcActive = (state_q != ST_IDLE);
  assign CalcMode   = cmd_q.rw;
  assign Busy       = busy;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Scoreboard bench for calc_seq_ctrl: directed scenarios then random traffic
// against a latency-level reference model; honours CALC_CMD_QUEUE_EN.
module tb_calc_seq_ctrl;

`ifdef CALC_CMD_QUEUE_EN
  localparam bit QUEUE = 1'b1;
`else
  localparam bit QUEUE = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        InputKey = 1'b0, ValidCmd = 1'b0, RW = 1'b0;
  logic [7:0]  Addr = '0, InA = '0, InB = '0;
  logic [3:0]  Sel = '0;
  logic        AluEn;
  logic [7:0]  AluA, AluB;
  logic [3:0]  AluSel;
  logic [15:0] AluResult;
  logic        MemWe, MemRe;
  logic [7:0]  MemAddr;
  logic [31:0] MemWdata;
  logic [31:0] MemRdata = '0;
  logic        SerStart;
  logic [31:0] SerData;
  logic        SerDone = 1'b0;
  logic        CalcActive, CalcMode, Busy;

  always #5 Clk = ~Clk;

  calc_seq_ctrl #(
    .ADDR_W(8), .OPND_W(8), .SEL_W(4), .ALU_W(16), .DATA_W(32), .KEY_SEQ(4'b1011)
  ) dut (
    .Clk(Clk), .Reset(Reset), .InputKey(InputKey), .ValidCmd(ValidCmd), .RW(RW),
    .Addr(Addr), .InA(InA), .InB(InB), .Sel(Sel),
    .AluEn(AluEn), .AluA(AluA), .AluB(AluB), .AluSel(AluSel), .AluResult(AluResult),
    .MemWe(MemWe), .MemRe(MemRe), .MemAddr(MemAddr), .MemWdata(MemWdata), .MemRdata(MemRdata),
    .SerStart(SerStart), .SerData(SerData), .SerDone(SerDone),
    .CalcActive(CalcActive), .CalcMode(CalcMode), .Busy(Busy)
  );

  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    case (s[1:0])
      2'd0:    return 16'(a) + 16'(b);
      2'd1:    return 16'(a) - 16'(b);
      2'd2:    return 16'(a) * 16'(b);
      default: return {a, b} ^ 16'h5A5A;
    endcase
  endfunction

  function automatic logic [31:0] mem_init(input int i);
    logic [7:0] v;
    v = 8'(i);
    return (i == 8'h34) ? 32'hDEADBEEF : {v, ~v, 16'hC0DE};
  endfunction

  // External ALU: only produces a meaningful result while enabled.
  assign AluResult = AluEn ? alu_fn(AluA, AluB, AluSel) : 16'hDEAD;

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  int n_we = 0, n_re = 0, n_ss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- environment: memory and serializer ----------------
  logic [31:0] env_mem [256];
  int          ser_cnt = 0;
  int          ser_delay = 8;
  bit          rnd_ser = 1'b0;
  bit          prev_re = 1'b0;
  logic [7:0]  prev_addr = '0;

  always @(posedge Clk) begin
    #1;
    if (!Reset) begin
      ser_cnt = 0;
      SerDone = 1'b0;
      prev_re = 1'b0;
    end else begin
      if (MemWe) env_mem[MemAddr] = MemWdata;
      MemRdata  = prev_re ? env_mem[prev_addr] : $urandom;
      prev_re   = MemRe;
      prev_addr = MemAddr;
      SerDone   = 1'b0;
      if (SerStart) begin
        ser_cnt = rnd_ser ? $urandom_range(1, 10) : ser_delay;
      end else if (ser_cnt > 0) begin
        ser_cnt--;
        if (ser_cnt == 0) SerDone = 1'b1;
      end else if (rnd_ser && $urandom_range(0, 7) == 0) begin
        SerDone = 1'b1;
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit         rw;
    logic [7:0] addr, a, b;
    logic [3:0] sel;
  } tcmd_t;

  typedef enum {EV_ALU, EV_WE, EV_RE, EV_SS} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    int          cyc;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [7:0]  a, b;
    logic [3:0]  sel;
  } ev_t;

  ev_t         exp_q[$];
  bit          kq[$];
  logic [31:0] ref_mem [256];
  bit          m_active, m_busy, m_rw, m_mode, m_pend;
  int          m_bidx;
  tcmd_t       m_pc;
  logic [31:0] m_tx;

  task automatic model_reset();
    m_active = 0; m_busy = 0; m_rw = 0; m_mode = 0; m_pend = 0; m_bidx = 0;
    kq.delete();
    exp_q.delete();
  endtask

  task automatic accept(input tcmd_t c);
    logic [31:0] res;
    m_busy = 1; m_bidx = 1; m_rw = c.rw; m_mode = c.rw;
    if (c.rw) begin
      res = {16'h0, alu_fn(c.a, c.b, c.sel)};
      exp_q.push_back('{kind: EV_ALU, cyc: cyc + 1, addr: c.addr, data: 0, a: c.a, b: c.b, sel: c.sel});
      exp_q.push_back('{kind: EV_WE, cyc: cyc + 2, addr: c.addr, data: res, a: 0, b: 0, sel: 0});
      ref_mem[c.addr] = res;
    end else begin
      m_tx = ref_mem[c.addr];
      exp_q.push_back('{kind: EV_RE, cyc: cyc + 1, addr: c.addr, data: 0, a: 0, b: 0, sel: 0});
      exp_q.push_back('{kind: EV_SS, cyc: cyc + 2, addr: c.addr, data: m_tx, a: 0, b: 0, sel: 0});
    end
  endtask

  task automatic model_step();
    bit    match;
    tcmd_t cur;
    cur = '{rw: RW, addr: Addr, a: InA, b: InB, sel: Sel};
    if (m_busy) begin
      if (QUEUE && ValidCmd && !m_pend) begin
        m_pend = 1;
        m_pc   = cur;
      end
      if (m_rw && m_bidx == 2) m_busy = 0;
      else if (!m_rw && m_bidx >= 3 && SerDone) m_busy = 0;
      else m_bidx++;
    end else begin
      kq.push_back(InputKey);
      if (kq.size() > 4) void'(kq.pop_front());
      match = (kq.size() == 4) && kq[0] && !kq[1] && kq[2] && kq[3];
      if (match) begin
        kq.delete();
        m_active = !m_active;
        m_pend   = 0;
      end else if (m_active && (m_pend || ValidCmd)) begin
        if (m_pend) accept(m_pc);
        else accept(cur);
        m_pend = 0;
      end
    end
  endtask

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) model_reset();
    else begin
      model_step();
      cyc++;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge Clk) begin
    logic [3:0] strobes, want;
    ev_t e;
    if (Reset === 1'b1) begin
      check("busy", Busy, m_busy);
      check("calc_active", CalcActive, m_active);
      check("calc_mode", CalcMode, m_mode);
      if (m_busy && !m_rw && m_bidx >= 2) check("ser_data_hold", SerData, m_tx);
      strobes = {AluEn, MemWe, MemRe, SerStart};
      if (MemWe) n_we++;
      if (MemRe) n_re++;
      if (SerStart) n_ss++;
      if (strobes != 4'b0) begin
        if (exp_q.size() == 0) begin
          check("spurious_strobe", strobes, 4'b0);
        end else begin
          e = exp_q.pop_front();
          case (e.kind)
            EV_ALU:  want = 4'b1000;
            EV_WE:   want = 4'b0100;
            EV_RE:   want = 4'b0010;
            default: want = 4'b0001;
          endcase
          check("strobe_kind", strobes, want);
          check("strobe_cycle", cyc, e.cyc);
          case (e.kind)
            EV_ALU: begin
              check("alu_a", AluA, e.a);
              check("alu_b", AluB, e.b);
              check("alu_sel", AluSel, e.sel);
            end
            EV_WE: begin
              check("we_addr", MemAddr, e.addr);
              check("we_data", MemWdata, e.data);
            end
            EV_RE:   check("re_addr", MemAddr, e.addr);
            default: check("ser_start_data", SerData, e.data);
          endcase
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic key, input logic vld, input logic rw,
                       input logic [7:0] addr, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] sel);
    InputKey = key; ValidCmd = vld; RW = rw; Addr = addr; InA = a; InB = b; Sel = sel;
    @(negedge Clk);
  endtask

  task automatic nop(input int n);
    repeat (n) drive(0, 0, 0, 8'h00, 8'h00, 8'h00, 4'h0);
  endtask

  task automatic key_seq();
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int k, we0, re0, ss0;
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = mem_init(i);
      ref_mem[i] = mem_init(i);
    end
    repeat (3) @(negedge Clk);
    check("rst_calc_active", CalcActive, 0);
    check("rst_busy", Busy, 0);
    check("rst_strobes", {AluEn, MemWe, MemRe, SerStart}, 4'b0);
    Reset = 1'b1;
    @(negedge Clk);

    // Activation pattern
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    check("key_partial", CalcActive, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    check("key_on", CalcActive, 1);

    // Write command
    drive(0, 1, 1, 8'h12, 8'd5, 8'd3, 4'h0);
    check("t3_alu_en", AluEn, 1);
    check("t3_busy1", Busy, 1);
    nop(1);
    check("t3_we", MemWe, 1);
    check("t3_addr", MemAddr, 8'h12);
    check("t3_wdata", MemWdata, 32'h0000_0008);
    check("t3_mode", CalcMode, 1);
    check("t3_busy2", Busy, 1);
    nop(1);
    check("t3_busy_drop", Busy, 0);

    // Read command, serializer completes 8 cycles after start
    drive(0, 1, 0, 8'h34, 8'h00, 8'h00, 4'h0);
    check("t4_re", MemRe, 1);
    nop(1);
    check("t4_ser_start", SerStart, 1);
    check("t4_ser_data", SerData, 32'hDEADBEEF);
    check("t4_mode", CalcMode, 0);
    k = 0;
    while (k < 30) begin
      nop(1);
      if (Busy !== 1'b1) break;
      k++;
    end
    check("t4_busy_len", k, 8);

    // Commands while busy
    we0 = n_we;
    drive(0, 1, 0, 8'h34, 8'h00, 8'h00, 4'h0);
    nop(1);
    drive(0, 1, 1, 8'h40, 8'd9, 8'd7, 4'h1);
    drive(0, 1, 1, 8'h41, 8'd2, 8'd4, 4'h2);
    nop(20);
    check("t5_we_count", n_we - we0, QUEUE ? 1 : 0);
    check("t5_busy_idle", Busy, 0);

    // Deactivate, then a command in IDLE must be ignored
    key_seq();
    check("t6_key_off", CalcActive, 0);
    we0 = n_we; re0 = n_re;
    drive(0, 1, 1, 8'h50, 8'd1, 8'd1, 4'h0);
    nop(3);
    check("t6_idle_ignored", n_we + n_re, we0 + re0);
    check("t6_idle_busy", Busy, 0);
    key_seq();
    check("t6_key_on", CalcActive, 1);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 8'h60, 8'd3, 8'd3, 4'h0);
    check("t6_deact_wins", CalcActive, 0);
    nop(3);
    check("t6_no_access", n_we + n_re, we0 + re0);

    // Asynchronous reset in the middle of a transmit
    key_seq();
    drive(0, 1, 0, 8'h34, 8'h00, 8'h00, 4'h0);
    nop(3);
    check("t1_in_tx", Busy, 1);
    ss0 = n_ss;
    #2 Reset = 1'b0;
    #1;
    check("t1_rst_active", CalcActive, 0);
    check("t1_rst_busy_mode", {Busy, CalcMode}, 2'b00);
    check("t1_rst_strobes", {AluEn, MemWe, MemRe, SerStart}, 4'b0);
    check("t1_rst_ser_data", SerData, 32'h0);
    check("t1_rst_regs", {MemAddr, MemWdata, AluA, AluB, AluSel}, '0);
    @(negedge Clk);
    Reset = 1'b1;
    nop(20);
    check("t1_no_ser_start", n_ss, ss0);
    check("t1_idle", CalcActive, 0);

    // Random traffic
    rnd_ser = 1'b1;
    repeat (3000) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 1'($urandom),
            8'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 4'($urandom));
    end
    nop(40);
    check("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
